mem_port_arbiter: RTL and testbench

//   Shares one DPI-backed RAM port (synchronous read, write-on-clock) between instruction fetch (IF) and load/store (LS).

---
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares a single synchronous-read RAM port between instruction fetch (IF)
// and load/store (LS). One transaction is in flight at a time; the winner is
// picked round-robin, the RAM strobe is driven for one cycle, the arbiter waits
// out the RAM read latency and then returns a one-cycle response to the owner.

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_valid,
    output logic              ls_ready,
    input  logic              ls_wen,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wmask,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wmask,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state;
    logic             owner_ls;
    logic             last_ls;
    logic             lat_wen;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant_if;
    logic             grant_ls;

    // Round-robin pick: LS wins a tie unless it won the previous tie-relevant
    // accept; a lone requester always wins. Nothing is granted outside idle or
    // while reset is held, so a reset cycle can never accept a request.
    always_comb begin
        grant_ls = 1'b0;
        grant_if = 1'b0;
        if (state == S_IDLE && !reset) begin
            grant_ls = ls_valid && (!if_valid || !last_ls);
            grant_if = if_valid && !grant_ls;
        end
    end

    assign if_ready  = grant_if;
    assign ls_ready  = grant_ls;

    // Strobes and response pulses are decoded from the state so that they last
    // exactly one cycle; reset suppresses them immediately.
    assign mem_ren   = (state == S_ISSUE) && !lat_wen && !reset;
    assign mem_wen   = (state == S_ISSUE) &&  lat_wen && !reset;
    assign if_rvalid = (state == S_RESP)  && !owner_ls && !reset;
    assign ls_rvalid = (state == S_RESP)  &&  owner_ls && !reset;

    // Read data is forwarded straight from the RAM in the response cycle;
    // a write acknowledgement carries zero data.
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = (ls_rvalid && !lat_wen) ? mem_rdata : '0;

    // Transaction sequencer: latch the granted request, issue it, wait out the
    // RAM latency, respond, and return to idle. The RAM address/data registers
    // only change on an accept, so they hold their value between strobes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            last_ls   <= 1'b0;
            owner_ls  <= 1'b0;
            lat_wen   <= 1'b0;
            wait_cnt  <= '0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_ls) begin
                        owner_ls <= grant_ls;
                        last_ls  <= grant_ls;
                        lat_wen  <= grant_ls && ls_wen;
                        if (grant_ls && ls_wen) begin
                            mem_waddr <= ls_addr;
                            mem_wmask <= ls_wmask;
                            mem_wdata <= ls_wdata;
                        end else begin
                            mem_raddr <= grant_ls ? ls_addr : if_addr;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= CNT_W'(RD_LAT - 1);
                    state    <= (RD_LAT == 1) ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt <= CNT_W'(1)) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Two arbiter instances share one clock and reset: lane 0 uses a 1-cycle RAM,
// lane 1 a 3-cycle RAM. Each lane has its own RAM model. A transaction-level
// reference model predicts, per cycle, which requester is granted, when the
// RAM strobe and the response must appear, and what data each response carries.

module tb_mem_port_arbiter;

    logic clock = 1'b0;
    logic reset;

    logic [1:0]       if_valid;
    logic [1:0]       ls_valid;
    logic [1:0]       ls_wen;
    logic [1:0][31:0] if_addr;
    logic [1:0][31:0] ls_addr;
    logic [1:0][31:0] ls_wmask;
    logic [1:0][31:0] ls_wdata;

    wire [1:0]       if_ready;
    wire [1:0]       ls_ready;
    wire [1:0]       if_rvalid;
    wire [1:0]       ls_rvalid;
    wire [1:0]       mem_ren;
    wire [1:0]       mem_wen;
    wire [1:0][31:0] if_rdata;
    wire [1:0][31:0] ls_rdata;
    wire [1:0][31:0] mem_raddr;
    wire [1:0][31:0] mem_rdata;
    wire [1:0][31:0] mem_waddr;
    wire [1:0][31:0] mem_wmask;
    wire [1:0][31:0] mem_wdata;

    int n_cmp  = 0;
    int n_bad  = 0;
    int to_cnt = 0;
    int cyc    = 0;

    bit          rst_prev;
    bit          final_chk;
    bit          final_done;
    bit          pend_v     [2];
    bit          pend_ls    [2];
    bit          pend_wen   [2];
    bit          last_ls    [2];
    logic [31:0] pend_addr  [2];
    logic [31:0] pend_wmask [2];
    logic [31:0] pend_wdata [2];
    logic [31:0] pend_exp   [2];
    int          issue_c    [2];
    int          resp_c     [2];
    int          exp_rsp    [2];
    int          got_rsp    [2];
    logic [31:0] shadow     [2][256];
    bit          shadow_has [2][256];

    always #5 clock = ~clock;

    // Power-on contents of every RAM word; word 0 holds the first instruction.
    function automatic logic [31:0] init_word(input int k, input int i);
        if (i == 0) return 32'h0000_0413;
        return (32'(i) * 32'h9E37_79B9) ^ (32'(k) << 16);
    endfunction

    function automatic logic [31:0] shadow_read(input int k, input logic [7:0] wi);
        return shadow_has[k][wi] ? shadow[k][wi] : init_word(k, int'(wi));
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] ram     [256];
        bit          ram_has [256];
        logic [31:0] rd_pipe [LAT];
        wire  [7:0]  wi = mem_waddr[g][9:2];
        wire  [7:0]  ri = mem_raddr[g][9:2];

        // RAM model: masked write commits on the edge, read data emerges LAT
        // cycles after the read strobe and then holds.
        always @(posedge clock) begin
            if (mem_wen[g]) begin
                ram[wi]     <= ((ram_has[wi] ? ram[wi] : init_word(g, int'(wi))) & ~mem_wmask[g])
                               | (mem_wdata[g] & mem_wmask[g]);
                ram_has[wi] <= 1'b1;
            end
            if (mem_ren[g]) begin
                rd_pipe[0] <= ram_has[ri] ? ram[ri] : init_word(g, int'(ri));
            end
            for (int s = 1; s < LAT; s++) begin
                rd_pipe[s] <= rd_pipe[s-1];
            end
        end

        assign mem_rdata[g] = rd_pipe[LAT-1];

        mem_port_arbiter #(
            .ADDR_W(32),
            .DATA_W(32),
            .RD_LAT(LAT)
        ) u_dut (
            .clock    (clock),
            .reset    (reset),
            .if_valid (if_valid[g]),
            .if_ready (if_ready[g]),
            .if_addr  (if_addr[g]),
            .if_rvalid(if_rvalid[g]),
            .if_rdata (if_rdata[g]),
            .ls_valid (ls_valid[g]),
            .ls_ready (ls_ready[g]),
            .ls_wen   (ls_wen[g]),
            .ls_addr  (ls_addr[g]),
            .ls_wmask (ls_wmask[g]),
            .ls_wdata (ls_wdata[g]),
            .ls_rvalid(ls_rvalid[g]),
            .ls_rdata (ls_rdata[g]),
            .mem_ren  (mem_ren[g]),
            .mem_raddr(mem_raddr[g]),
            .mem_rdata(mem_rdata[g]),
            .mem_wen  (mem_wen[g]),
            .mem_waddr(mem_waddr[g]),
            .mem_wmask(mem_wmask[g]),
            .mem_wdata(mem_wdata[g])
        );
    end

    task automatic checkOutput(input string tag, input int k,
                               input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("[TB] FAIL lane%0d %s: observed %h expected %h", k, tag, obs, exp);
        end
    endtask

    // One cycle of the reference model for lane k, evaluated mid-cycle.
    task automatic modelStep(input int k);
        bit          idle, e_if, e_ls, e_ren, e_wen, e_irv, e_lrv;
        logic [7:0]  wi;
        int          lat;
        lat = (k == 0) ? 1 : 3;
        if (!reset && rst_prev) begin
            checkOutput("post_reset_raddr", k, mem_raddr[k], 32'd0);
            checkOutput("post_reset_waddr", k, mem_waddr[k], 32'd0);
            checkOutput("post_reset_wmask", k, mem_wmask[k], 32'd0);
            checkOutput("post_reset_wdata", k, mem_wdata[k], 32'd0);
        end
        if (reset) begin
            checkOutput("reset_if_ready",  k, 32'(if_ready[k]),  32'd0);
            checkOutput("reset_ls_ready",  k, 32'(ls_ready[k]),  32'd0);
            checkOutput("reset_if_rvalid", k, 32'(if_rvalid[k]), 32'd0);
            checkOutput("reset_ls_rvalid", k, 32'(ls_rvalid[k]), 32'd0);
            checkOutput("reset_mem_ren",   k, 32'(mem_ren[k]),   32'd0);
            checkOutput("reset_mem_wen",   k, 32'(mem_wen[k]),   32'd0);
            if (pend_v[k]) exp_rsp[k]--;
            pend_v[k]  = 1'b0;
            last_ls[k] = 1'b0;
        end else begin
            idle  = !pend_v[k];
            e_ls  = idle && ls_valid[k] && (!if_valid[k] || !last_ls[k]);
            e_if  = idle && if_valid[k] && !e_ls;
            e_ren = pend_v[k] && cyc == issue_c[k] && !pend_wen[k];
            e_wen = pend_v[k] && cyc == issue_c[k] &&  pend_wen[k];
            e_irv = pend_v[k] && cyc == resp_c[k]  && !pend_ls[k];
            e_lrv = pend_v[k] && cyc == resp_c[k]  &&  pend_ls[k];
            checkOutput("if_ready",  k, 32'(if_ready[k]),  32'(e_if));
            checkOutput("ls_ready",  k, 32'(ls_ready[k]),  32'(e_ls));
            checkOutput("mem_ren",   k, 32'(mem_ren[k]),   32'(e_ren));
            checkOutput("mem_wen",   k, 32'(mem_wen[k]),   32'(e_wen));
            checkOutput("if_rvalid", k, 32'(if_rvalid[k]), 32'(e_irv));
            checkOutput("ls_rvalid", k, 32'(ls_rvalid[k]), 32'(e_lrv));
            if (e_ren) checkOutput("mem_raddr", k, mem_raddr[k], pend_addr[k]);
            if (e_wen) begin
                checkOutput("mem_waddr", k, mem_waddr[k], pend_addr[k]);
                checkOutput("mem_wmask", k, mem_wmask[k], pend_wmask[k]);
                checkOutput("mem_wdata", k, mem_wdata[k], pend_wdata[k]);
            end
            if (e_irv) checkOutput("if_rdata", k, if_rdata[k], pend_exp[k]);
            if (e_lrv) checkOutput("ls_rdata", k, ls_rdata[k], pend_exp[k]);
            if (if_rvalid[k] || ls_rvalid[k]) got_rsp[k]++;
            if (pend_v[k] && cyc == resp_c[k]) pend_v[k] = 1'b0;
            if (e_if || e_ls) begin
                pend_v[k]     = 1'b1;
                pend_ls[k]    = e_ls;
                pend_wen[k]   = e_ls && ls_wen[k];
                pend_addr[k]  = e_ls ? ls_addr[k] : if_addr[k];
                pend_wmask[k] = ls_wmask[k];
                pend_wdata[k] = ls_wdata[k];
                wi = pend_addr[k][9:2];
                if (pend_wen[k]) begin
                    shadow[k][wi]     = (shadow_read(k, wi) & ~ls_wmask[k]) | (ls_wdata[k] & ls_wmask[k]);
                    shadow_has[k][wi] = 1'b1;
                    pend_exp[k]       = 32'd0;
                end else begin
                    pend_exp[k] = shadow_read(k, wi);
                end
                issue_c[k] = cyc + 1;
                resp_c[k]  = cyc + 1 + lat;
                last_ls[k] = e_ls;
                exp_rsp[k]++;
            end
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Mid-cycle monitor: step both lane models, then run the end-of-test checks once.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) modelStep(k);
        rst_prev = reset;
        if (final_chk && !final_done) begin
            final_done = 1'b1;
            for (int k = 0; k < 2; k++) begin
                checkOutput("response_count", k, 32'(got_rsp[k]), 32'(exp_rsp[k]));
            end
            checkOutput("accept_timeout", 0, 32'(to_cnt), 32'd0);
        end
    end

    // Present up to one IF and one LS request on lane k and hold each until it
    // is accepted; returns one cycle after the last accept.
    task automatic applyStimulus(input int k, input bit want_if, input logic [31:0] iaddr,
                                 input bit want_ls, input bit lwen, input logic [31:0] laddr,
                                 input logic [31:0] lmask, input logic [31:0] ldata);
        bit gi, gl;
        if_valid[k] = want_if;
        if_addr[k]  = iaddr;
        ls_valid[k] = want_ls;
        ls_wen[k]   = lwen;
        ls_addr[k]  = laddr;
        ls_wmask[k] = lmask;
        ls_wdata[k] = ldata;
        for (int t = 0; t < 60 && (if_valid[k] || ls_valid[k]); t++) begin
            @(negedge clock);
            gi = if_valid[k] && if_ready[k];
            gl = ls_valid[k] && ls_ready[k];
            @(posedge clock);
            #1;
            if (gi) if_valid[k] = 1'b0;
            if (gl) ls_valid[k] = 1'b0;
        end
        if (if_valid[k] || ls_valid[k]) begin
            to_cnt++;
            if_valid[k] = 1'b0;
            ls_valid[k] = 1'b0;
        end
    endtask

    // IF stays valid every transaction; LS joins on roughly a third of them.
    task automatic runRandom(input int k, input int n);
        logic [7:0]  w8;
        logic [31:0] a_if, a_ls;
        for (int i = 0; i < n; i++) begin
            w8   = 8'($urandom_range(255, 0));
            a_if = {22'd0, w8, 2'b00};
            w8   = 8'($urandom_range(255, 0));
            a_ls = {22'd0, w8, 2'b00};
            applyStimulus(k, 1'b1, a_if, ($urandom_range(2, 0) == 0), 1'($urandom_range(1, 0)),
                          a_ls, $urandom, $urandom);
        end
    endtask

    task automatic waitIdle();
        repeat (8) @(posedge clock);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        if_valid  = '0;
        ls_valid  = '0;
        ls_wen    = '0;
        if_addr   = '0;
        ls_addr   = '0;
        ls_wmask  = '0;
        ls_wdata  = '0;
        final_chk = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Lane 0, one-cycle RAM: first fetch, tie alternation, write then read back.
        applyStimulus(0, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        applyStimulus(0, 1'b1, 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 32'h0);
        applyStimulus(0, 1'b1, 32'h0000_0044, 1'b1, 1'b0, 32'h0000_0084, 32'h0, 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0104, 32'h0000_FFFF, 32'h1234_5678);
        applyStimulus(0, 1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        runRandom(0, 40);
        waitIdle();

        // Lane 1, three-cycle RAM: single fetch, then reset while an LS read waits.
        applyStimulus(1, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        waitIdle();
        applyStimulus(1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(1, 1'b1, 32'h0000_0204, 1'b1, 1'b0, 32'h0000_0208, 32'h0, 32'h0);
        runRandom(1, 30);
        waitIdle();

        final_chk = 1'b1;
        @(negedge clock);
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
